// File: rtl/conv_encoder_stream.sv
// rtl/conv_encoder_stream.sv - handshaked convolutional encoder and radix-4 branch-table generator
//
// Encode mode (i_mode_sel=1): consumes i_frame_len bits on i_bit/i_bit_valid/o_bit_ready
// and emits one rate-1/2 or rate-1/3 symbol per bit on o_data/o_valid/i_ready.
// Table mode (i_mode_sel=0): walks every (state, 2-bit pair) transition and emits
// {pair, state, second, first} on o_mux for the Viterbi branch-metric unit.
// Configuration, latched on i_start: i_code_rate, i_constr_len (K=3/5/7/9),
// i_gen_poly (poly i at [i*MAX_K +: MAX_K]), i_frame_len.
// Status: o_busy while not idle, o_done one-cycle completion pulse.
// Optional feature macro: CE_TAIL_EN appends K-1 zero tail bits in encode mode.
module conv_encoder_stream #(
    parameter int MAX_K    = 9,
    parameter int MAX_RATE = 3,
    parameter int FRAME_W  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic                                 i_mode_sel,
    input  logic                                 i_code_rate,
    input  logic [1:0]                           i_constr_len,
    input  logic [MAX_RATE*MAX_K-1:0]            i_gen_poly,
    input  logic [FRAME_W-1:0]                   i_frame_len,
    input  logic                                 i_bit,
    input  logic                                 i_bit_valid,
    output logic                                 o_bit_ready,
    output logic [MAX_RATE-1:0]                  o_data,
    output logic [2+(MAX_K-1)+2*MAX_RATE-1:0]    o_mux,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic                                 o_busy,
    output logic                                 o_done
);
    localparam int SW = MAX_K - 1;

    typedef enum logic [2:0] {IDLE, ENC, TAIL, TBL, DONE} fsm_t;

    fsm_t                      fsm;
    logic                      rate_r;
    logic [1:0]                cl_r;
    logic [MAX_RATE*MAX_K-1:0] poly_r;
    logic [FRAME_W-1:0]        flen_r;
    logic [SW-1:0]             shreg;
    // idx counts info bits in ENC, tail bits in TAIL and {state, pair} in TBL
    logic [FRAME_W-1:0]        idx;
    // fin: the last item of the current phase is already in the output register,
    // only its downstream handshake is outstanding
    logic                      fin;

    logic [MAX_K-1:0]          k_mask;
    logic [FRAME_W-1:0]        tbl_last;

    always_comb begin
        k_mask = '0;
        for (int k = 0; k < MAX_K; k++) begin
            if (k < 3 + 2 * int'(cl_r)) k_mask[k] = 1'b1;
        end
        // 4 * 2^(K-1) entries = 2^(K+1)
        tbl_last = FRAME_W'((1 << (4 + 2 * int'(cl_r))) - 1);
    end

    function automatic logic [MAX_RATE-1:0] enc(input logic [MAX_K-1:0] v);
        logic [MAX_RATE-1:0] r;
        for (int i = 0; i < MAX_RATE; i++) begin
            r[i] = ^(poly_r[i*MAX_K +: MAX_K] & v & k_mask);
        end
        if (!rate_r) begin
            for (int i = 2; i < MAX_RATE; i++) r[i] = 1'b0;
        end
        return r;
    endfunction

    logic                load;
    logic                out_hs;
    logic                bit_hs;
    logic [1:0]          tbl_pair;
    logic [SW-1:0]       tbl_st;
    logic [MAX_RATE-1:0] enc_sym;
    logic [MAX_RATE-1:0] tbl_first;
    logic [MAX_RATE-1:0] tbl_second;

    assign load        = !o_valid || i_ready;
    assign out_hs      = o_valid && i_ready;
    assign o_bit_ready = (fsm == ENC) && !fin && load;
    assign bit_hs      = o_bit_ready && i_bit_valid;

    assign tbl_pair    = idx[1:0];
    assign tbl_st      = idx[SW+1:2];
    assign enc_sym     = enc({shreg, i_bit});
    assign tbl_first   = enc({tbl_st, tbl_pair[0]});
    // second symbol starts from the state reached after pair[0]
    assign tbl_second  = enc({tbl_st[SW-2:0], tbl_pair[0], tbl_pair[1]});

`ifdef CE_TAIL_EN
    logic [MAX_RATE-1:0] tail_sym;
    logic [FRAME_W-1:0]  tail_last;
    assign tail_sym  = enc({shreg, 1'b0});
    assign tail_last = FRAME_W'(1 + 2 * int'(cl_r));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            rate_r  <= 1'b0;
            cl_r    <= 2'b00;
            poly_r  <= '0;
            flen_r  <= '0;
            shreg   <= '0;
            idx     <= '0;
            fin     <= 1'b0;
            o_data  <= '0;
            o_mux   <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (out_hs) o_valid <= 1'b0;

            case (fsm)
                IDLE: begin
                    if (i_start) begin
                        rate_r <= i_code_rate;
                        cl_r   <= i_constr_len;
                        poly_r <= i_gen_poly;
                        flen_r <= i_frame_len;
                        shreg  <= '0;
                        idx    <= '0;
                        fin    <= 1'b0;
                        o_busy <= 1'b1;
                        if (!i_mode_sel) begin
                            fsm <= TBL;
                        end else if (i_frame_len == '0) begin
`ifdef CE_TAIL_EN
                            fsm    <= TAIL;
`else
                            fsm    <= DONE;
                            o_done <= 1'b1;
`endif
                        end else begin
                            fsm <= ENC;
                        end
                    end
                end

                ENC: begin
                    if (bit_hs) begin
                        o_data  <= enc_sym;
                        o_mux   <= '0;
                        o_valid <= 1'b1;
                        shreg   <= {shreg[SW-2:0], i_bit} & k_mask[MAX_K-1:1];
                        if (idx == flen_r - FRAME_W'(1)) begin
                            idx <= '0;
`ifdef CE_TAIL_EN
                            fsm <= TAIL;
`else
                            fin <= 1'b1;
`endif
                        end else begin
                            idx <= idx + FRAME_W'(1);
                        end
                    end else if (fin && out_hs) begin
                        fsm    <= DONE;
                        o_done <= 1'b1;
                    end
                end

`ifdef CE_TAIL_EN
                TAIL: begin
                    if (!fin && load) begin
                        o_data  <= tail_sym;
                        o_mux   <= '0;
                        o_valid <= 1'b1;
                        shreg   <= {shreg[SW-2:0], 1'b0} & k_mask[MAX_K-1:1];
                        if (idx == tail_last) fin <= 1'b1;
                        else                  idx <= idx + FRAME_W'(1);
                    end else if (fin && out_hs) begin
                        fsm    <= DONE;
                        o_done <= 1'b1;
                    end
                end
`endif

                TBL: begin
                    if (!fin && load) begin
                        o_mux   <= {tbl_pair, tbl_st, tbl_second, tbl_first};
                        o_data  <= '0;
                        o_valid <= 1'b1;
                        if (idx == tbl_last) fin <= 1'b1;
                        else                 idx <= idx + FRAME_W'(1);
                    end else if (fin && out_hs) begin
                        fsm    <= DONE;
                        o_done <= 1'b1;
                    end
                end

                DONE: begin
                    fsm    <= IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    fsm    <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// tb/tb_conv_encoder_stream.sv - directed self-checking bench for conv_encoder_stream
module tb_conv_encoder_stream;
`ifdef CE_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_mode_sel, i_code_rate;
    logic [1:0]  i_constr_len;
    logic [26:0] i_gen_poly;
    logic [15:0] i_frame_len;
    logic        i_bit, i_bit_valid, o_bit_ready;
    logic [2:0]  o_data;
    logic [15:0] o_mux;
    logic        o_valid, i_ready, o_busy, o_done;

    always #5 clk = ~clk;

    conv_encoder_stream dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode_sel(i_mode_sel),
        .i_code_rate(i_code_rate), .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly),
        .i_frame_len(i_frame_len), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
        .o_bit_ready(o_bit_ready), .o_data(o_data), .o_mux(o_mux), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
    );

    int          checks = 0;
    int          failures = 0;
    logic        bits [0:127];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          done_cnt, done_gap, first_v;
    logic [15:0] other_or;
    logic        bit2_seen, finished;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] menc(input logic [9:0] v, input int kk,
                                        input logic [26:0] poly, input logic rate);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < kk; k++)
                r[i] = r[i] ^ (poly[i*9+k] & v[k]);
        if (!rate) r[2] = 1'b0;
        return r;
    endfunction

    task automatic model_enc(input int kk, input logic [26:0] poly, input logic rate, input int flen);
        logic [9:0] v;
        logic [7:0] st;
        int         ntail;
        st = 8'h00;
        exp_q.delete();
        ntail = TAIL_EN ? kk - 1 : 0;
        for (int n = 0; n < flen + ntail; n++) begin
            v = {1'b0, st, (n < flen) ? bits[n] : 1'b0};
            exp_q.push_back({13'd0, menc(v, kk, poly, rate)});
            st = v[7:0] & 8'((1 << (kk - 1)) - 1);
        end
    endtask

    task automatic model_tbl(input int kk, input logic [26:0] poly, input logic rate);
        logic [7:0] s8;
        logic [1:0] pr;
        logic [2:0] f, se;
        exp_q.delete();
        for (int s = 0; s < (1 << (kk - 1)); s++) begin
            for (int p = 0; p < 4; p++) begin
                s8 = 8'(s);
                pr = 2'(p);
                f  = menc({1'b0, s8, pr[0]}, kk, poly, rate);
                se = menc({s8, pr[0], pr[1]}, kk, poly, rate);
                exp_q.push_back({pr, s8, se, f});
            end
        end
    endtask

    task automatic cmp_q(input string tag);
        check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    // Entered and left at posedge+1. Cycle 0 carries the start pulse.
    task automatic run(input logic mode, input logic rate, input logic [1:0] cl,
                       input logic [26:0] poly, input int flen,
                       input int st_lo, input int st_hi, input int rst_at);
        int   j, c, last_hs;
        logic hs;
        got_q.delete();
        done_cnt = 0; done_gap = -1; first_v = -1; other_or = '0;
        bit2_seen = 1'b0; finished = 1'b0;
        i_mode_sel = mode; i_code_rate = rate; i_constr_len = cl;
        i_gen_poly = poly; i_frame_len = 16'(flen);
        j = 0; last_hs = 0;
        for (c = 0; c < 4000; c++) begin
            i_start     = (c == 0);
            i_ready     = !(c >= st_lo && c < st_hi);
            i_bit_valid = mode && (j < flen);
            i_bit       = (j < flen) ? bits[j] : 1'b0;
            if (rst_at >= 0 && j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_o_valid", o_valid, 0);
                check("rst_o_data", o_data, 0);
                check("rst_o_busy", o_busy, 0);
                check("rst_o_bit_ready", o_bit_ready, 0);
                check("rst_o_done", o_done, 0);
                rst = 1'b0;
                @(posedge clk); #1;
                finished = 1'b1;
                break;
            end
            @(negedge clk);
            if (o_done) begin
                done_cnt++;
                done_gap = c - last_hs;
            end
            if (o_valid && i_ready) begin
                if (first_v < 0) first_v = c;
                got_q.push_back(mode ? {13'd0, o_data} : o_mux);
                other_or = other_or | (mode ? o_mux : {13'd0, o_data});
                if (o_data[2]) bit2_seen = 1'b1;
                last_hs = c;
            end
            if (!i_ready && o_valid) check("stall_bit_ready", o_bit_ready, 0);
            hs = o_bit_ready && i_bit_valid;
            @(posedge clk); #1;
            if (hs) j++;
            if (done_cnt > 0) begin
                check("busy_after_done", o_busy, 0);
                finished = 1'b1;
                break;
            end
        end
        i_start = 1'b0; i_bit_valid = 1'b0; i_ready = 1'b1;
        check("run_finished", finished, 1);
    endtask

    localparam logic [26:0] P_K3 = {9'h1FF, 9'h005, 9'h007};
    localparam logic [26:0] P_K5 = {9'h019, 9'h01B, 9'h015};
    localparam logic [26:0] P_K9 = {9'h1F3, 9'h1AD, 9'h16F};

    initial begin
        rst = 1'b1; i_start = 1'b0; i_mode_sel = 1'b0; i_code_rate = 1'b0;
        i_constr_len = 2'b00; i_gen_poly = '0; i_frame_len = '0;
        i_bit = 1'b0; i_bit_valid = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_o_data", o_data, 0);
        check("reset_o_mux", o_mux, 0);
        check("reset_o_valid", o_valid, 0);
        check("reset_o_bit_ready", o_bit_ready, 0);
        check("reset_o_busy", o_busy, 0);
        check("reset_o_done", o_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // K=3 rate 1/2, bits 1,0,1,1 (hand-computed symbols)
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
        run(1'b1, 1'b0, 2'b00, P_K3, 4, -1, -1, -1);
        exp_q.delete();
        exp_q.push_back(16'd3); exp_q.push_back(16'd1);
        exp_q.push_back(16'd0); exp_q.push_back(16'd2);
        if (TAIL_EN) begin
            exp_q.push_back(16'd2); exp_q.push_back(16'd3);
        end
        cmp_q("enc_k3");
        check("enc_k3_first_valid", first_v, 2);
        check("enc_k3_done_cnt", done_cnt, 1);
        check("enc_k3_done_gap", done_gap, 1);
        check("enc_k3_mux_zero", other_or, 0);

        // table mode K=3
        run(1'b0, 1'b0, 2'b00, P_K3, 0, -1, -1, -1);
        model_tbl(3, P_K3, 1'b0);
        cmp_q("tbl_k3");
        if (got_q.size() > 2) check("tbl_k3_entry2", got_q[2], 16'h8018);
        else                  check("tbl_k3_entry2_present", got_q.size(), 16);
        check("tbl_k3_first_valid", first_v, 2);
        check("tbl_k3_done_gap", done_gap, 1);
        check("tbl_k3_data_zero", other_or, 0);

        // backpressure: K=5 rate 1/3, i_ready low for 3 cycles mid-frame
        bits[0] = 1; bits[1] = 1; bits[2] = 0; bits[3] = 1; bits[4] = 0;
        bits[5] = 0; bits[6] = 1; bits[7] = 1; bits[8] = 1; bits[9] = 0;
        run(1'b1, 1'b1, 2'b01, P_K5, 10, 5, 8, -1);
        model_enc(5, P_K5, 1'b1, 10);
        cmp_q("bp_k5");
        check("bp_k5_done_gap", done_gap, 1);

        // zero-length frame, K=5
        run(1'b1, 1'b0, 2'b01, P_K5, 0, -1, -1, -1);
        exp_q.delete();
        if (TAIL_EN) repeat (4) exp_q.push_back(16'd0);
        cmp_q("flen0_k5");
        check("flen0_done_cnt", done_cnt, 1);
        check("flen0_done_gap", done_gap, 1);

        // K=9 rate 1/3, 64 random bits
        for (int i = 0; i < 64; i++) bits[i] = 1'($urandom_range(0, 1));
        run(1'b1, 1'b1, 2'b11, P_K9, 64, -1, -1, -1);
        model_enc(9, P_K9, 1'b1, 64);
        cmp_q("rnd_k9");
        check("rnd_k9_count", got_q.size(), TAIL_EN ? 72 : 64);
        check("rnd_k9_bit2_active", bit2_seen, 1);

        // reset after 5 of 10 bits, then a clean frame from state 0
        for (int i = 0; i < 10; i++) bits[i] = 1'(i % 3 != 1);
        run(1'b1, 1'b0, 2'b01, P_K5, 10, -1, -1, 5);
        check("abort_no_done", done_cnt, 0);
        run(1'b1, 1'b0, 2'b01, P_K5, 10, -1, -1, -1);
        model_enc(5, P_K5, 1'b0, 10);
        cmp_q("after_rst_k5");
        check("after_rst_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_encoder_stream.md
# conv_encoder_stream

Parametrised, handshaked successor of the convolutional encoder stage. In encode mode it accepts a framed bit stream, emits one rate-1/2 or rate-1/3 code symbol per input bit, and appends a zero tail that returns the trellis to state 0. In table mode it scans every (state, 2-bit input pair) transition and emits the radix-4 branch table consumed by the Viterbi branch-metric unit. It sits between the input framer and the channel or decoder path.

## Interface
- MAX_K, 9: maximum constraint length; state width is MAX_K-1.
- MAX_RATE, 3: maximum number of code outputs per input bit.
- FRAME_W, 16: width of the frame-length field.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; accepted only when o_busy=0.
- i_mode_sel  in  1  0 = table mode, 1 = encode mode. Latched at start.
- i_code_rate  in  1  0 = rate 1/2, 1 = rate 1/3. Latched at start.
- i_constr_len  in  2  00/01/10/11 selects K = 3/5/7/9. Latched at start.
- i_gen_poly  in  MAX_RATE x MAX_K  generator polynomials; bit k taps the input delayed by k. Latched at start.
- i_frame_len  in  FRAME_W  number of information bits. Latched at start.
- i_bit, i_bit_valid  in  1,1  input bit stream.
- o_bit_ready  out  1  input handshake.
- o_data  out  MAX_RATE  code symbol; bit i comes from poly i.
- o_mux  out  2+(MAX_K-1)+2*MAX_RATE  table entry: {pair, state, second, first}.
- o_valid  out  1  o_data/o_mux valid. Shared by both modes.
- i_ready  in  1  downstream ready.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ENC, TAIL, TBL, DONE.
  - IDLE→ENC on start with mode=1. If i_frame_len=0, go directly to TAIL.
  - IDLE→TBL on start with mode=0.
  - DONE→IDLE unconditionally after one cycle.
- Encode function: form v = {state, b}, where v[0] is the newest bit. Output i = XOR over k<K of (poly[i][k] & v[k]).
  - Poly bits at k≥K are masked.
  - In rate 1/2, o_data[2] = 0.
- ENC: each input handshake produces one symbol; state becomes {state[K-3:0], b}, masked to K-1 bits.
  - After i_frame_len accepted bits, move to TAIL.
- TAIL: inject K-1 zero bits internally, with o_bit_ready=0. Final state = 0.
  - DONE is entered on the handshake of the last tail symbol.
  - Total symbols per frame = i_frame_len + K - 1.
- TBL: state is the outer counter (0..2^(K-1)-1) and pair is the inner counter (0..3), giving 4·2^(K-1) entries.
  - first = enc({state, pair[0]}).
  - second = enc({state[K-2:0], pair[0], pair[1]}).
  - The state field is zero-extended; unused rate bits are 0.
  - DONE is entered on the handshake of the last entry.
- o_mux is 0 in encode mode; o_data is 0 in table mode.
- i_start while busy is ignored.

## Timing
- Reset values: o_data=0, o_mux=0, o_valid=0, o_bit_ready=0, o_busy=0, o_done=0. FSM=IDLE, shift state=0, counters=0.
- Output register is single-entry. It loads when (!o_valid || i_ready).
- o_bit_ready = (FSM==ENC) && (!o_valid || i_ready).
- Encode latency: a symbol appears on o_valid the cycle after its input handshake. Throughput is 1 bit/cycle with i_ready held high.
- Table mode: start at cycle 0, first entry valid at cycle 2, then one entry per cycle while i_ready=1.
- Stall: while o_valid && !i_ready, o_data, o_mux and all counters hold.
- o_done asserts the cycle after the final output handshake and lasts exactly 1 cycle. o_busy falls in the same cycle o_done falls.
- Reset mid-frame: all outputs clear immediately. Partial output is discarded and no o_done is issued.

## Configuration
- CE_TAIL_EN defined: TAIL state present; behaviour as above.
- CE_TAIL_EN undefined:
  - ENC→DONE on the handshake of the last info symbol. Total symbols = i_frame_len.
  - Shift state is cleared to 0 on the next start.
  - frame_len=0 goes IDLE→DONE.

## Test plan
- Encode, K=3, rate 1/2, polys 3'b111/3'b101, bits 1,0,1,1 -> o_data sequence 3,1,0,2,2,3, o_done 1 cycle after the 6th handshake.
- Table, K=3, same polys -> 16 entries in state-major order; entry 2 (state 0, pair 2'b10) o_mux=16'h8018; o_done after entry 16.
- Backpressure: drop i_ready for 3 cycles mid-frame -> o_data and o_valid held, o_bit_ready=0, no symbol lost or duplicated.
- i_frame_len=0, K=5 -> 4 all-zero tail symbols, then o_done. Without CE_TAIL_EN -> immediate o_done, no o_valid.
- Rate 1/3, K=9, polys 9'h16F/9'h1AD/9'h1F3, 64 random bits -> matches reference model, 72 symbols, o_data[2] active.
- Assert rst after 5 of 10 bits -> all outputs 0 next cycle; a new start encodes from state 0 correctly.
